alu_issue_unit: RTL and testbench
=================================

Name: alu_issue_unit

Overview:
- Issue/decode stage that feeds the one-hot-opcode ALU execution stage: the ID/EX end of the interface.
- Accepts RISC-V R-type instruction words over a valid/ready handshake and reads operands from an internal 32x32 register file.
- Encodes funct7/funct3 into the one-hot ALU opcode, drives id_ex_a/id_ex_b/opcode/load, waits the ALU latency, captures alu_result and writes it back.
- Strictly one instruction in flight; no forwarding needed.

Parameters:
ALU_LATENCY, 2, number of consecutive load-high cycles per issue; alu_result is sampled on the edge after the last load cycle (min 1)
XLEN, 32, operand/result width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  instruction valid
in_ready  output  1  unit can accept instruction (high only in IDLE)
instr  input  32  RISC-V instruction word
cfg_we  input  1  register-file preload write enable
cfg_addr  input  5  preload address
cfg_wdata  input  XLEN  preload data
id_ex_a  output  XLEN  operand A (rs1 value), signed
id_ex_b  output  XLEN  operand B (rs2 value), signed
opcode  output  6  one-hot ALU opcode
load  output  1  ALU load strobe
alu_result  input  XLEN  result from ALU
wb_valid  output  1  one-cycle writeback pulse
wb_rd  output  5  writeback destination
wb_data  output  XLEN  writeback value
illegal  output  1  one-cycle pulse on an undecodable instruction
issued_count  output  32  performance counter (see Optional Feature)
illegal_count  output  32  performance counter (see Optional Feature)

Behaviour:
- Reset: clk and rst_n as already decided (rst_n asynchronous, active-low). All outputs are 0 except in_ready=1. State is IDLE, register file is cleared to 0, and the counters are 0.
- Decode applies only when instr[6:0]=0110011. Otherwise the instruction is illegal. Encodings (funct7, funct3 -> opcode):
  - ADD: 0000000, 000 -> 000001
  - SUB: 0100000, 000 -> 000010
  - AND: 0000000, 111 -> 000100
  - OR: 0000000, 110 -> 001000
  - SLT: 0000000, 010 -> 010000
  - MUL: 0000001, 000 -> 100000
  - Any other combination is illegal.
- FSM IDLE:
  - in_ready=1. The handshake fires at edge E0 when in_valid&in_ready.
  - Legal instruction: latch rd, opcode, and operands rf[rs1] and rf[rs2]; x0 reads 0. Go to ISSUE and set the counter to ALU_LATENCY-1.
  - Illegal instruction: register illegal=1 for one cycle, then stay in IDLE. The next accept is possible the cycle after. No load is issued and there is no writeback.
- FSM ISSUE:
  - load=1 and opcode/id_ex_a/id_ex_b are held constant for exactly ALU_LATENCY cycles (E0..E_LAT).
  - The counter decrements each edge. When it reaches 0, at edge E_LAT, go to CAPTURE and deassert load, opcode and operands (all 0).
- FSM CAPTURE:
  - At edge E_LAT+1, sample alu_result into wb_data and set wb_rd=rd. wb_valid is high for the single following cycle.
  - Write rf[rd]=alu_result unless rd=0. wb_valid still pulses for rd=0.
  - Return to IDLE.
- Throughput: one legal instruction per ALU_LATENCY+2 cycles.
- opcode is 000000 whenever load=0. opcode is never driven non-one-hot.
- cfg writes are accepted in any state, take effect at the edge, and cfg writes to x0 are ignored.
  - If a cfg write and a CAPTURE writeback hit the same address at the same edge, the writeback wins.
  - A cfg write to rs1/rs2 after the operands are latched does not alter the in-flight operands.
- in_valid while not in_ready: the instruction is not consumed. The producer holds it.
- Reset mid-ISSUE or mid-CAPTURE aborts immediately:
  - load drops and no writeback occurs.
  - The register file is cleared.
- Arithmetic is done by the ALU. This block is width-transparent: no sign extension or truncation of alu_result.

Optional Feature:
Macro ISSUE_PERF_CNT_EN.
- Defined: issued_count increments once per legal accept and illegal_count once per illegal accept. Both are 32-bit, wrap 0xFFFFFFFF->0, and are cleared by reset.
- Undefined: no counter flops exist, and both ports are tied to 0.

Test Plan:
- ADD: cfg x1=5, x2=7. Issue add x3,x1,x2 (0x002081B3). load is high for 2 cycles with opcode=000001, a=5, b=7; model ALU returns 12 -> wb_valid with wb_rd=3, wb_data=12, rf[3]=12, 4 cycles per instruction.
- SUB/SLT: x1=5, x2=7. sub x4,x1,x2 -> opcode 000010, wb_data=0xFFFFFFFE. slt x5,x1,x2 -> opcode 010000, wb_data=1.
- MUL and x0: x1=0x00010000, x2=0x00010000. mul x0,x1,x2 -> opcode 100000, wb_valid pulses, wb_data=0, rf[0] reads 0 afterwards.
- Illegal: instr=0x402071B3 (funct7=0100000, funct3=111) -> illegal pulse for 1 cycle, load never asserted, no wb_valid, in_ready back high the next cycle; illegal_count=1 with ISSUE_PERF_CNT_EN defined.
- Backpressure/collision: hold in_valid with a second ADD during ISSUE -> in_ready=0 and the ADD is accepted only after CAPTURE. A cfg write of x3=99 at the CAPTURE edge targeting rd=3 -> rf[3] holds the ALU result.
- Reset mid-ISSUE: assert rst_n=0 during the first load cycle -> load=0 and in_ready=1 immediately, no wb_valid, all registers read 0 after release.

Source files
------------

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: R-type decode/issue stage driving the one-hot ALU; optional perf counters under ISSUE_PERF_CNT_EN
module alu_issue_unit #(
    parameter int ALU_LATENCY = 2,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic            cfg_we,
    input  logic [4:0]      cfg_addr,
    input  logic [XLEN-1:0] cfg_wdata,
    output logic [XLEN-1:0] id_ex_a,
    output logic [XLEN-1:0] id_ex_b,
    output logic [5:0]      opcode,
    output logic            load,
    input  logic [XLEN-1:0] alu_result,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            illegal,
    output logic [31:0]     issued_count,
    output logic [31:0]     illegal_count
);
    localparam int CW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] rf [32];
    logic [CW-1:0]   cnt;
    logic [4:0]      rd_q;
    logic [9:0]      fn;
    logic [5:0]      dec_op;
    logic            legal;
    logic            accept;

    assign fn     = {instr[31:25], instr[14:12]};
    assign dec_op = (instr[6:0] != 7'b0110011) ? 6'b000000 :
                    (fn == 10'b0000000_000)    ? 6'b000001 :
                    (fn == 10'b0100000_000)    ? 6'b000010 :
                    (fn == 10'b0000000_111)    ? 6'b000100 :
                    (fn == 10'b0000000_110)    ? 6'b001000 :
                    (fn == 10'b0000000_010)    ? 6'b010000 :
                    (fn == 10'b0000001_000)    ? 6'b100000 : 6'b000000;
    assign legal    = |dec_op;
    assign in_ready = (state == IDLE);
    assign accept   = in_valid & in_ready;

    // next state: accept -> hold load for ALU_LATENCY cycles -> one capture cycle -> idle
    always_comb begin
        state_n = (state == IDLE)  ? ((accept && legal) ? ISSUE : IDLE) :
                  (state == ISSUE) ? ((cnt == '0) ? CAPTURE : ISSUE) : IDLE;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // issue registers, writeback and register file (writeback overrides a same-edge cfg write)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
            cnt      <= '0;
            rd_q     <= '0;
            load     <= 1'b0;
            opcode   <= '0;
            id_ex_a  <= '0;
            id_ex_b  <= '0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            illegal  <= 1'b0;
        end else begin
            illegal  <= accept && !legal;
            wb_valid <= 1'b0;
            if (cfg_we && cfg_addr != 5'd0) rf[cfg_addr] <= cfg_wdata;
            if (accept && legal) begin
                load    <= 1'b1;
                opcode  <= dec_op;
                id_ex_a <= rf[instr[19:15]];
                id_ex_b <= rf[instr[24:20]];
                rd_q    <= instr[11:7];
                cnt     <= CW'(ALU_LATENCY - 1);
            end else if (state == ISSUE) begin
                if (cnt == '0) begin
                    load    <= 1'b0;
                    opcode  <= '0;
                    id_ex_a <= '0;
                    id_ex_b <= '0;
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end else if (state == CAPTURE) begin
                wb_valid <= 1'b1;
                wb_rd    <= rd_q;
                wb_data  <= alu_result;
                if (rd_q != 5'd0) rf[rd_q] <= alu_result;
            end
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    // accept counters, wrapping at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_count  <= '0;
            illegal_count <= '0;
        end else begin
            if (accept && legal)  issued_count  <= issued_count + 32'd1;
            if (accept && !legal) illegal_count <= illegal_count + 32'd1;
        end
    end
`else
    assign issued_count  = '0;
    assign illegal_count = '0;
`endif
endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: directed checks of decode, issue timing, writeback, illegal, backpressure and reset abort
module tb_alu_issue_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic        cfg_we = 1'b0;
    logic [4:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic [31:0] id_ex_a, id_ex_b;
    logic [5:0]  opcode;
    logic        load;
    logic [31:0] alu_result = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
    logic [31:0] issued_count, illegal_count;
    int total = 0;
    int bad = 0;

`ifdef ISSUE_PERF_CNT_EN
    localparam logic [31:0] EXP_ISS = 32'd7;
    localparam logic [31:0] EXP_ILL = 32'd2;
`else
    localparam logic [31:0] EXP_ISS = 32'd0;
    localparam logic [31:0] EXP_ILL = 32'd0;
`endif

    alu_issue_unit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .id_ex_a(id_ex_a), .id_ex_b(id_ex_b), .opcode(opcode), .load(load),
        .alu_result(alu_result), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .illegal(illegal), .issued_count(issued_count), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load) begin
            case (opcode)
                6'b000001: alu_result <= id_ex_a + id_ex_b;
                6'b000010: alu_result <= id_ex_a - id_ex_b;
                6'b000100: alu_result <= id_ex_a & id_ex_b;
                6'b001000: alu_result <= id_ex_a | id_ex_b;
                6'b010000: alu_result <= {31'd0, $signed(id_ex_a) < $signed(id_ex_b)};
                6'b100000: alu_result <= id_ex_a * id_ex_b;
                default:   alu_result <= 32'hDEADBEEF;
            endcase
        end
    end

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    task automatic cfg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [31:0] w);
        @(negedge clk);
        in_valid = 1'b1; instr = w;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL wait_idle timeout in_ready=%0b exp=1", in_ready);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
        total++; if (load !== 1'b0) begin bad++; $display("FAIL rst_load got=%0b exp=0", load); end
        total++; if (opcode !== 6'd0) begin bad++; $display("FAIL rst_opcode got=%b exp=0", opcode); end
        total++; if (wb_valid !== 1'b0 || illegal !== 1'b0) begin bad++; $display("FAIL rst_pulses wb=%0b ill=%0b exp=0", wb_valid, illegal); end
        total++; if (wb_data !== 32'd0 || id_ex_a !== 32'd0) begin bad++; $display("FAIL rst_data wb=%h a=%h exp=0", wb_data, id_ex_a); end
        total++; if (issued_count !== 32'd0 || illegal_count !== 32'd0) begin bad++; $display("FAIL rst_counts %0d %0d exp=0", issued_count, illegal_count); end
        rst_n = 1'b1;
    endtask

    task automatic test_alu_ops();
        logic [31:0] va [6] = '{32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'h00010000};
        logic [31:0] vb [6] = '{32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'h00010000};
        logic [6:0]  f7 [6] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h01};
        logic [2:0]  f3 [6] = '{3'b000, 3'b000, 3'b010, 3'b111, 3'b110, 3'b000};
        logic [4:0]  rd [6] = '{5'd3, 5'd4, 5'd5, 5'd7, 5'd8, 5'd0};
        logic [5:0]  op [6] = '{6'b000001, 6'b000010, 6'b010000, 6'b000100, 6'b001000, 6'b100000};
        logic [31:0] rs [6] = '{32'd12, 32'hFFFFFFFE, 32'd1, 32'd5, 32'd7, 32'd0};
        for (int i = 0; i < 6; i++) begin
            cfg(5'd1, va[i]);
            cfg(5'd2, vb[i]);
            send(enc(f7[i], f3[i], rd[i], 5'd1, 5'd2));
            total++; if (load !== 1'b1 || opcode !== op[i]) begin bad++; $display("FAIL op%0d_issue load=%0b op=%b exp=1 %b", i, load, opcode, op[i]); end
            total++; if (id_ex_a !== va[i] || id_ex_b !== vb[i]) begin bad++; $display("FAIL op%0d_operands a=%h b=%h exp=%h %h", i, id_ex_a, id_ex_b, va[i], vb[i]); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL op%0d_busy in_ready=%0b exp=0", i, in_ready); end
            @(negedge clk);
            total++; if (load !== 1'b1 || opcode !== op[i]) begin bad++; $display("FAIL op%0d_hold load=%0b op=%b exp=1 %b", i, load, opcode, op[i]); end
            @(negedge clk);
            total++; if (load !== 1'b0 || opcode !== 6'd0 || wb_valid !== 1'b0) begin bad++; $display("FAIL op%0d_drop load=%0b op=%b wb=%0b exp=0", i, load, opcode, wb_valid); end
            @(negedge clk);
            total++; if (wb_valid !== 1'b1 || wb_rd !== rd[i] || wb_data !== rs[i]) begin bad++; $display("FAIL op%0d_wb v=%0b rd=%0d d=%h exp=1 %0d %h", i, wb_valid, wb_rd, wb_data, rd[i], rs[i]); end
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL op%0d_ready in_ready=%0b exp=1", i, in_ready); end
            @(negedge clk);
            total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL op%0d_wb_pulse wb=%0b exp=0", i, wb_valid); end
        end
        cfg(5'd0, 32'd77);
        send(enc(7'h00, 3'b000, 5'd6, 5'd0, 5'd3));
        total++; if (id_ex_a !== 32'd0 || id_ex_b !== 32'd12) begin bad++; $display("FAIL rf_readback a=%h b=%h exp=0 c", id_ex_a, id_ex_b); end
        wait_idle();
    endtask

    task automatic test_illegal();
        send(32'h402071B3);
        total++; if (illegal !== 1'b1 || load !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL ill_pulse ill=%0b load=%0b rdy=%0b exp=1 0 1", illegal, load, in_ready); end
        @(negedge clk);
        total++; if (illegal !== 1'b0 || load !== 1'b0 || wb_valid !== 1'b0) begin bad++; $display("FAIL ill_after ill=%0b load=%0b wb=%0b exp=0", illegal, load, wb_valid); end
        send(32'h00000013);
        total++; if (illegal !== 1'b1 || load !== 1'b0) begin bad++; $display("FAIL ill_opc ill=%0b load=%0b exp=1 0", illegal, load); end
        total++; if (issued_count !== EXP_ISS || illegal_count !== EXP_ILL) begin bad++; $display("FAIL counts iss=%0d ill=%0d exp=%0d %0d", issued_count, illegal_count, EXP_ISS, EXP_ILL); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        cfg(5'd1, 32'd5);
        cfg(5'd2, 32'd7);
        @(negedge clk);
        in_valid = 1'b1; instr = enc(7'h00, 3'b000, 5'd3, 5'd1, 5'd2);
        @(negedge clk);
        instr = enc(7'h00, 3'b000, 5'd9, 5'd1, 5'd2);
        cfg_we = 1'b1; cfg_addr = 5'd1; cfg_wdata = 32'd50;
        @(negedge clk);
        cfg_we = 1'b0;
        total++; if (id_ex_a !== 32'd5 || load !== 1'b1) begin bad++; $display("FAIL b2b_inflight a=%0d load=%0b exp=5 1", id_ex_a, load); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_backpressure rdy=%0b exp=0", in_ready); end
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 5'd3; cfg_wdata = 32'd99;
        total++; if (in_ready !== 1'b0 || load !== 1'b0) begin bad++; $display("FAIL b2b_drop rdy=%0b load=%0b exp=0 0", in_ready, load); end
        @(negedge clk);
        cfg_we = 1'b0;
        total++; if (wb_valid !== 1'b1 || wb_data !== 32'd12 || in_ready !== 1'b1 || load !== 1'b0) begin bad++; $display("FAIL b2b_wb1 v=%0b d=%0d rdy=%0b load=%0b exp=1 12 1 0", wb_valid, wb_data, in_ready, load); end
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (load !== 1'b1 || id_ex_a !== 32'd50 || id_ex_b !== 32'd7) begin bad++; $display("FAIL b2b_second load=%0b a=%0d b=%0d exp=1 50 7", load, id_ex_a, id_ex_b); end
        while (!wb_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        total++; if (wb_valid !== 1'b1 || wb_rd !== 5'd9 || wb_data !== 32'd57) begin bad++; $display("FAIL b2b_wb2 v=%0b rd=%0d d=%0d exp=1 9 57", wb_valid, wb_rd, wb_data); end
        send(enc(7'h00, 3'b000, 5'd10, 5'd3, 5'd0));
        total++; if (id_ex_a !== 32'd12) begin bad++; $display("FAIL b2b_collision rf3=%0d exp=12", id_ex_a); end
        wait_idle();
    endtask

    task automatic test_reset_mid_issue();
        cfg(5'd1, 32'd5);
        send(enc(7'h00, 3'b000, 5'd3, 5'd1, 5'd2));
        total++; if (load !== 1'b1) begin bad++; $display("FAIL rmi_load_before load=%0b exp=1", load); end
        rst_n = 1'b0;
        #1;
        total++; if (load !== 1'b0 || in_ready !== 1'b1 || opcode !== 6'd0) begin bad++; $display("FAIL rmi_abort load=%0b rdy=%0b op=%b exp=0 1 0", load, in_ready, opcode); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (wb_valid !== 1'b0 || load !== 1'b0) begin bad++; $display("FAIL rmi_quiet%0d wb=%0b load=%0b exp=0", i, wb_valid, load); end
        end
        rst_n = 1'b1;
        total++; if (issued_count !== 32'd0 || illegal_count !== 32'd0) begin bad++; $display("FAIL rmi_counts %0d %0d exp=0", issued_count, illegal_count); end
        send(enc(7'h00, 3'b000, 5'd11, 5'd1, 5'd2));
        total++; if (id_ex_a !== 32'd0 || id_ex_b !== 32'd0) begin bad++; $display("FAIL rmi_rf_cleared a=%h b=%h exp=0", id_ex_a, id_ex_b); end
        send(enc(7'h00, 3'b000, 5'd12, 5'd3, 5'd9));
        total++; if (in_ready !== 1'b1 && load === 1'b1 && id_ex_a !== 32'd0) begin bad++; $display("FAIL rmi_rf3 a=%h exp=0", id_ex_a); end
        wait_idle();
        send(enc(7'h00, 3'b000, 5'd12, 5'd3, 5'd9));
        total++; if (id_ex_a !== 32'd0 || id_ex_b !== 32'd0) begin bad++; $display("FAIL rmi_rf39 a=%h b=%h exp=0", id_ex_a, id_ex_b); end
        wait_idle();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_alu_ops();
        test_illegal();
        test_back_to_back();
        test_reset_mid_issue();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
